// File: rtl/uart_pkg.sv
// Shared UART frame layout and receiver/transmitter FSM state codes.
package uart_pkg;

   localparam int FRAME_W    = 11;
   localparam int DATA_W     = 8;
   localparam int START_IDX  = 0;
   localparam int PARITY_IDX = 9;
   localparam int STOP_IDX   = 10;

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] START      = 3'd1;
   localparam logic [2:0] DATA       = 3'd2;
   localparam logic [2:0] PARITY     = 3'd3;
   localparam logic [2:0] STOP       = 3'd4;
   localparam logic [2:0] BREAK_WAIT = 3'd5;

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous line that idles high.
module uart_sync2 (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   // Two back-to-back flops; reset to the idle (high) level.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: start, 8 data bits LSB first, parity, stop.
// Bits are sampled at their midpoint using a divider latched at the start edge.
import uart_pkg::*;

module uart_receiver #(
   parameter bit PARITY_ODD = 1'b0,
   parameter int DIV_W      = 16
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [DIV_W-1:0]   div,
   input  logic               rxd,
   output logic [FRAME_W-1:0] frame,
   output logic [DATA_W-1:0]  data,
   output logic               valid,
   output logic               parity_err,
   output logic               frame_err,
   output logic               busy
);

   localparam int VLD_STAGES = 1;

   logic               rxd_s;
   logic               rxd_d;
   logic               fall;
   logic [2:0]         state;
   logic [DIV_W-1:0]   div_eff;
   logic [DIV_W-1:0]   div_l;
   logic [DIV_W-1:0]   half;
   logic [DIV_W-1:0]   cnt;
   logic [2:0]         bit_cnt;
   logic [DATA_W-1:0]  data_sr;
   logic               par_b;
   logic [VLD_STAGES:0] vld_pipe;

   uart_sync2 u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rxd),
      .q     (rxd_s)
   );

   assign fall    = ~rxd_s & rxd_d;
   assign div_eff = (div < DIV_W'(2)) ? DIV_W'(2) : div;
   assign half    = {1'b0, div_l[DIV_W-1:1]};
   assign busy    = (state != IDLE);
   assign valid   = vld_pipe[VLD_STAGES];

   // Frame FSM. cnt counts cycles since the last reference edge (start
   // detection or previous sample), so a value of 1 means "one cycle later".
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= IDLE;
         rxd_d      <= 1'b1;
         div_l      <= DIV_W'(2);
         cnt        <= '0;
         bit_cnt    <= '0;
         data_sr    <= '0;
         par_b      <= 1'b0;
         frame      <= '1;
         data       <= '0;
         parity_err <= 1'b0;
         frame_err  <= 1'b0;
         vld_pipe   <= '0;
      end else begin
         rxd_d    <= rxd_s;
         vld_pipe <= {vld_pipe[VLD_STAGES-1:0], 1'b0};
         cnt      <= cnt + 1'b1;
         case (state)
            IDLE: begin
               if (fall) begin
                  div_l   <= div_eff;
                  bit_cnt <= '0;
                  cnt     <= DIV_W'(1);
                  // With div < 4 the start midpoint is the detection edge
                  // itself, where rxd_s is already known to be 0.
                  if (div_eff < DIV_W'(4)) state <= DATA;
                  else                     state <= START;
               end
            end
            START: begin
               if (cnt == half - 1'b1) begin
                  if (rxd_s) begin
                     state <= IDLE;
                  end else begin
                     cnt   <= DIV_W'(1);
                     state <= DATA;
                  end
               end
            end
            DATA: begin
               if (cnt == div_l) begin
                  cnt     <= DIV_W'(1);
                  data_sr <= {rxd_s, data_sr[DATA_W-1:1]};
                  bit_cnt <= bit_cnt + 1'b1;
                  if (bit_cnt == 3'd7) state <= PARITY;
               end
            end
            PARITY: begin
               if (cnt == div_l) begin
                  cnt   <= DIV_W'(1);
                  par_b <= rxd_s;
                  state <= STOP;
               end
            end
            STOP: begin
               if (cnt == div_l) begin
                  frame[START_IDX]    <= 1'b0;
                  frame[DATA_W:1]     <= data_sr;
                  frame[PARITY_IDX]   <= par_b;
                  frame[STOP_IDX]     <= rxd_s;
                  data                <= data_sr;
                  parity_err          <= ((^data_sr) ^ par_b) != PARITY_ODD;
                  frame_err           <= ~rxd_s;
                  vld_pipe[0]         <= 1'b1;
                  state               <= rxd_s ? IDLE : BREAK_WAIT;
               end
            end
            BREAK_WAIT: begin
               if (rxd_s) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_receiver.sv
// Randomized self-checking bench for uart_receiver with a frame-level model.
module tb_uart_receiver;

   localparam bit PARITY_ODD = 1'b0;

   logic        clk;
   logic        rst_n;
   logic [15:0] div;
   logic        rxd;
   logic [10:0] frame;
   logic [7:0]  data;
   logic        valid;
   logic        parity_err;
   logic        frame_err;
   logic        busy;

   typedef struct {
      int          cyc;
      logic [10:0] frame;
      logic [7:0]  data;
      logic        pe;
      logic        fe;
   } rec_t;

   rec_t        q[$];
   int          cyc;
   int          t0;
   int          checks;
   int          errors;
   logic [10:0] last_frame;

   uart_receiver #(.PARITY_ODD(PARITY_ODD), .DIV_W(16)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .div        (div),
      .rxd        (rxd),
      .frame      (frame),
      .data       (data),
      .valid      (valid),
      .parity_err (parity_err),
      .frame_err  (frame_err),
      .busy       (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Record every valid pulse together with the outputs it qualifies.
   always @(negedge clk) begin
      if (valid) q.push_back('{cyc, frame, data, parity_err, frame_err});
   end

   // Even/odd parity bit that makes the frame correct.
   function automatic logic good_par(input logic [7:0] d);
      return logic'(($countones(d) % 2) != 0) ^ PARITY_ODD;
   endfunction

   // Drive the first nbits bits of a frame; div is scrambled mid-frame
   // because the receiver must use the value seen at the start edge.
   task automatic drive_frame(input logic [7:0] d, input logic par, input logic stop,
                              input int dv, input int nbits);
      logic [10:0] f;
      int de;
      f   = {stop, par, d, 1'b0};
      de  = (dv < 2) ? 2 : dv;
      div = 16'(dv);
      t0  = cyc + 1;
      for (int k = 0; k < nbits; k++) begin
         rxd = f[k];
         if (k == 2) div = 16'($urandom_range(2, 40));
         repeat (de) @(negedge clk);
      end
      rxd = 1'b1;
   endtask

   task automatic test_reset;
      rst_n = 1'b0; rxd = 1'b1; div = 16'd16;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks += 6;
      if (frame !== 11'h7FF) begin errors++; $display("FAIL reset_frame got %h exp 7ff", frame); end
      if (data !== 8'h00) begin errors++; $display("FAIL reset_data got %h exp 00", data); end
      if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
      if (parity_err !== 1'b0) begin errors++; $display("FAIL reset_perr got %b exp 0", parity_err); end
      if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_ferr got %b exp 0", frame_err); end
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
      q.delete();
      last_frame = 11'h7FF;
   endtask

   task automatic test_basic;
      rec_t r;
      drive_frame(8'hA5, 1'b0, 1'b1, 16, 11);
      repeat (4) @(negedge clk);
      checks++;
      if (q.size() != 1) begin
         errors++; $display("FAIL basic_count got %0d exp 1", q.size());
      end else begin
         r = q.pop_front();
         checks += 5;
         if (r.cyc != t0 + 170) begin errors++; $display("FAIL basic_time got %0d exp %0d", r.cyc - t0, 170); end
         if (r.data !== 8'hA5) begin errors++; $display("FAIL basic_data got %h exp a5", r.data); end
         if (r.frame !== 11'h54A) begin errors++; $display("FAIL basic_frame got %h exp 54a", r.frame); end
         if (r.pe !== 1'b0) begin errors++; $display("FAIL basic_perr got %b exp 0", r.pe); end
         if (r.fe !== 1'b0) begin errors++; $display("FAIL basic_ferr got %b exp 0", r.fe); end
      end
      q.delete();
      last_frame = 11'h54A;
   endtask

   task automatic test_parity;
      rec_t r;
      drive_frame(8'h01, 1'b0, 1'b1, 16, 11);
      repeat (4) @(negedge clk);
      checks++;
      if (q.size() != 1) begin
         errors++; $display("FAIL par_count got %0d exp 1", q.size());
      end else begin
         r = q.pop_front();
         checks += 3;
         if (r.data !== 8'h01) begin errors++; $display("FAIL par_data got %h exp 01", r.data); end
         if (r.pe !== 1'b1) begin errors++; $display("FAIL par_perr got %b exp 1", r.pe); end
         if (r.fe !== 1'b0) begin errors++; $display("FAIL par_ferr got %b exp 0", r.fe); end
      end
      checks++;
      if (parity_err !== 1'b1) begin errors++; $display("FAIL par_hold got %b exp 1", parity_err); end
      q.delete();
      drive_frame(8'h01, good_par(8'h01), 1'b1, 16, 11);
      repeat (4) @(negedge clk);
      checks++;
      if (parity_err !== 1'b0) begin errors++; $display("FAIL par_clear got %b exp 0", parity_err); end
      q.delete();
      last_frame = {1'b1, good_par(8'h01), 8'h01, 1'b0};
   endtask

   task automatic test_break;
      rec_t r;
      drive_frame(8'h3C, good_par(8'h3C), 1'b0, 16, 11);
      rxd = 1'b0;
      repeat (40) @(negedge clk);
      checks += 2;
      if (busy !== 1'b1) begin errors++; $display("FAIL brk_busy got %b exp 1", busy); end
      if (frame_err !== 1'b1) begin errors++; $display("FAIL brk_ferr got %b exp 1", frame_err); end
      rxd = 1'b1;
      repeat (4) @(negedge clk);
      checks += 2;
      if (busy !== 1'b0) begin errors++; $display("FAIL brk_idle got %b exp 0", busy); end
      if (q.size() != 1) begin errors++; $display("FAIL brk_count got %0d exp 1", q.size()); end
      q.delete();
      drive_frame(8'h55, good_par(8'h55), 1'b1, 16, 11);
      repeat (4) @(negedge clk);
      checks++;
      if (q.size() != 1) begin
         errors++; $display("FAIL brk_next_count got %0d exp 1", q.size());
      end else begin
         r = q.pop_front();
         checks += 3;
         if (r.data !== 8'h55) begin errors++; $display("FAIL brk_next_data got %h exp 55", r.data); end
         if (r.pe !== 1'b0) begin errors++; $display("FAIL brk_next_perr got %b exp 0", r.pe); end
         if (r.fe !== 1'b0) begin errors++; $display("FAIL brk_next_ferr got %b exp 0", r.fe); end
      end
      q.delete();
      last_frame = {1'b1, good_par(8'h55), 8'h55, 1'b0};
   endtask

   task automatic test_glitch;
      div = 16'd16;
      rxd = 1'b0;
      repeat (3) @(negedge clk);
      rxd = 1'b1;
      repeat (30) @(negedge clk);
      checks += 3;
      if (q.size() != 0) begin errors++; $display("FAIL glitch_count got %0d exp 0", q.size()); end
      if (busy !== 1'b0) begin errors++; $display("FAIL glitch_busy got %b exp 0", busy); end
      if (frame !== last_frame) begin errors++; $display("FAIL glitch_frame got %h exp %h", frame, last_frame); end
      q.delete();
   endtask

   task automatic test_small_div;
      rec_t r;
      for (int dv = 0; dv <= 2; dv++) begin
         drive_frame(8'hFF, good_par(8'hFF), 1'b1, dv, 11);
         repeat (6) @(negedge clk);
         checks++;
         if (q.size() != 1) begin
            errors++; $display("FAIL div%0d_count got %0d exp 1", dv, q.size());
         end else begin
            r = q.pop_front();
            checks += 3;
            if (r.data !== 8'hFF) begin errors++; $display("FAIL div%0d_data got %h exp ff", dv, r.data); end
            if (r.pe !== 1'b0) begin errors++; $display("FAIL div%0d_perr got %b exp 0", dv, r.pe); end
            if (r.cyc != t0 + 23) begin errors++; $display("FAIL div%0d_time got %0d exp 23", dv, r.cyc - t0); end
         end
         q.delete();
      end
      last_frame = {1'b1, good_par(8'hFF), 8'hFF, 1'b0};
   endtask

   task automatic test_reset_mid;
      rec_t r;
      drive_frame(8'h81, good_par(8'h81), 1'b1, 16, 5);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      checks += 4;
      if (frame !== 11'h7FF) begin errors++; $display("FAIL rmid_frame got %h exp 7ff", frame); end
      if (data !== 8'h00) begin errors++; $display("FAIL rmid_data got %h exp 00", data); end
      if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b exp 0", busy); end
      if (valid !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b exp 0", valid); end
      repeat (100) @(negedge clk);
      checks++;
      if (q.size() != 0) begin errors++; $display("FAIL rmid_spurious got %0d exp 0", q.size()); end
      q.delete();
      drive_frame(8'h81, good_par(8'h81), 1'b1, 16, 11);
      repeat (4) @(negedge clk);
      checks++;
      if (q.size() != 1) begin
         errors++; $display("FAIL rmid_next_count got %0d exp 1", q.size());
      end else begin
         r = q.pop_front();
         checks += 2;
         if (r.data !== 8'h81) begin errors++; $display("FAIL rmid_next_data got %h exp 81", r.data); end
         if (r.pe !== 1'b0) begin errors++; $display("FAIL rmid_next_perr got %b exp 0", r.pe); end
      end
      q.delete();
   endtask

   task automatic test_back_to_back;
      rec_t r;
      logic [7:0] d[3];
      for (int i = 0; i < 3; i++) begin
         d[i] = 8'($urandom);
         drive_frame(d[i], good_par(d[i]), 1'b1, 10, 11);
      end
      repeat (6) @(negedge clk);
      checks++;
      if (q.size() != 3) begin
         errors++; $display("FAIL b2b_count got %0d exp 3", q.size());
      end else begin
         for (int i = 0; i < 3; i++) begin
            r = q.pop_front();
            checks++;
            if (r.data !== d[i]) begin errors++; $display("FAIL b2b_data%0d got %h exp %h", i, r.data, d[i]); end
         end
      end
      q.delete();
   endtask

   task automatic test_random;
      rec_t r;
      logic [7:0] d;
      logic good, stop, par;
      logic [10:0] ef;
      int dv;
      for (int n = 0; n < 20; n++) begin
         d    = 8'($urandom);
         dv   = $urandom_range(0, 24);
         good = ($urandom_range(0, 3) != 0);
         stop = ($urandom_range(0, 4) != 0);
         par  = good ? good_par(d) : ~good_par(d);
         ef   = {stop, par, d, 1'b0};
         drive_frame(d, par, stop, dv, 11);
         repeat ($urandom_range(4, 8)) @(negedge clk);
         checks++;
         if (q.size() != 1) begin
            errors++; $display("FAIL rnd%0d_count got %0d exp 1", n, q.size());
         end else begin
            r = q.pop_front();
            checks += 4;
            if (r.frame !== ef) begin errors++; $display("FAIL rnd%0d_frame got %h exp %h", n, r.frame, ef); end
            if (r.data !== d) begin errors++; $display("FAIL rnd%0d_data got %h exp %h", n, r.data, d); end
            if (r.pe !== !good) begin errors++; $display("FAIL rnd%0d_perr got %b exp %b", n, r.pe, !good); end
            if (r.fe !== !stop) begin errors++; $display("FAIL rnd%0d_ferr got %b exp %b", n, r.fe, !stop); end
         end
         q.delete();
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      rxd    = 1'b1;
      div    = 16'd16;
      @(negedge clk);
      test_reset;
      test_basic;
      test_parity;
      test_break;
      test_glitch;
      test_small_div;
      test_reset_mid;
      test_back_to_back;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
